// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/gnt/rvalid data port, store lane alignment, load extraction.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being force-aligned.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_addr_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [3:0]  dmem_wstrb_out,
    output logic [31:0] dmem_wdata_out,
    input  logic        dmem_gnt_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        stall_out,
    output logic        wb_valid_out,
    output logic        wb_rf_wr_out,
    output logic [4:0]  wb_rd_addr_out,
    output logic [31:0] wb_data_out,
    output logic        bus_err_out,
    output logic        misalign_out
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              latch_en;
    logic              mem_op, is_byte, is_half, timeout;
    logic [1:0]        lane_in;
    logic [3:0]        wstrb_in;
    logic [31:0]       wdata_in;

    logic              we_q, load_q, uns_q;
    logic [1:0]        size_q, lane_q;
    logic [4:0]        rd_q;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        wstrb_q;

    logic              wb_valid_q, wb_valid_d, wb_rf_wr_q, wb_rf_wr_d, bus_err_q, bus_err_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
`ifdef MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d, misaligned_in;
`endif

    function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = rdata >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign mem_op  = valid_in & (load_in | store_in);
    assign is_byte = (load_size_in == 2'b00);
    assign is_half = (load_size_in == 2'b01);
    // Without the trap, the low address bits are forced to the access alignment here.
    assign lane_in  = is_byte ? addr_in[1:0] : (is_half ? {addr_in[1], 1'b0} : 2'b00);
    assign wstrb_in = ~store_in ? 4'b0000 :
                      is_byte   ? (4'b0001 << lane_in) :
                      is_half   ? (4'b0011 << lane_in) : 4'b1111;
    assign wdata_in = is_byte ? {4{store_data_in[7:0]}} :
                      is_half ? {2{store_data_in[15:0]}} : store_data_in;
`ifdef MISALIGN_TRAP_EN
    assign misaligned_in = (is_half & addr_in[0]) | (~is_byte & ~is_half & (addr_in[1:0] != 2'b00));
`endif

    assign cnt_inc = cnt_q + 1'b1;
    assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        latch_en   = 1'b0;
        wb_valid_d = 1'b0;
        wb_rf_wr_d = 1'b0;
        wb_rd_d    = '0;
        wb_data_d  = '0;
        bus_err_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    latch_en = 1'b1;
                    state_d  = REQ;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned_in) begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_addr_in;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (dmem_gnt_in && we_q) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                end else if (timeout) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    bus_err_d  = 1'b1;
                end else if (dmem_gnt_in) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                cnt_d = cnt_inc;
                if (dmem_rvalid_in) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_rf_wr_d = load_q & (rd_q != 5'd0);
                    wb_data_d  = extract_load(dmem_rdata_in, size_q, lane_q, uns_q);
                end else if (timeout) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    bus_err_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rf_wr_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            bus_err_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rf_wr_q <= wb_rf_wr_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            bus_err_q  <= bus_err_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            lane_q  <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if (latch_en) begin
            we_q    <= store_in;
            load_q  <= load_in;
            uns_q   <= load_unsigned_in;
            size_q  <= load_size_in;
            lane_q  <= lane_in;
            rd_q    <= rd_addr_in;
            addr_q  <= {addr_in[31:2], 2'b00};
            wstrb_q <= wstrb_in;
            wdata_q <= wdata_in;
        end
    end

    assign dmem_req_out   = (state_q == REQ);
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = addr_q;
    assign dmem_wstrb_out = wstrb_q;
    assign dmem_wdata_out = wdata_q;
    // Gated by reset so the stall is low while reset is held even if an op sits on the inputs.
    assign stall_out      = rst_in & (((state_q == IDLE) & mem_op) | (state_q == REQ) | (state_q == RSP));
    assign wb_valid_out   = wb_valid_q;
    assign wb_rf_wr_out   = wb_rf_wr_q;
    assign wb_rd_addr_out = wb_rd_q;
    assign wb_data_out    = wb_data_q;
    assign bus_err_out    = bus_err_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_out   = misalign_q;
`else
    assign misalign_out   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit: table of single transactions plus timeout, misalign and reset sequences.
module tb_load_store_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        valid_in = 1'b0, load_in = 1'b0, store_in = 1'b0, load_unsigned_in = 1'b0;
    logic [1:0]  load_size_in = 2'b00;
    logic [31:0] addr_in = '0, store_data_in = '0;
    logic [4:0]  rd_addr_in = '0;
    logic        dmem_req_out, dmem_we_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out;
    logic [3:0]  dmem_wstrb_out;
    logic        dmem_gnt_in = 1'b0, dmem_rvalid_in = 1'b0;
    logic [31:0] dmem_rdata_in = '0;
    logic        stall_out, wb_valid_out, wb_rf_wr_out, bus_err_out, misalign_out;
    logic [4:0]  wb_rd_addr_out;
    logic [31:0] wb_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .valid_in(valid_in), .load_in(load_in), .store_in(store_in),
        .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
        .addr_in(addr_in), .store_data_in(store_data_in), .rd_addr_in(rd_addr_in),
        .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out),
        .dmem_wstrb_out(dmem_wstrb_out), .dmem_wdata_out(dmem_wdata_out),
        .dmem_gnt_in(dmem_gnt_in), .dmem_rvalid_in(dmem_rvalid_in), .dmem_rdata_in(dmem_rdata_in),
        .stall_out(stall_out), .wb_valid_out(wb_valid_out), .wb_rf_wr_out(wb_rf_wr_out),
        .wb_rd_addr_out(wb_rd_addr_out), .wb_data_out(wb_data_out),
        .bus_err_out(bus_err_out), .misalign_out(misalign_out)
    );

    typedef struct {
        string       nm;
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        int          gd;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic        e_rf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        valid_in = 1'b1; load_in = v.ld; store_in = v.st; load_size_in = v.sz;
        load_unsigned_in = v.uns; addr_in = v.addr; store_data_in = v.wd; rd_addr_in = v.rd;
    endtask

    task automatic clear_op();
        valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_op(input vec_t v);
        drive_op(v);
        #1;
        chk({v.nm, ".stall_idle"}, 32'(stall_out), 32'd1);
        step();
        chk({v.nm, ".req"}, 32'(dmem_req_out), 32'd1);
        chk({v.nm, ".we"}, 32'(dmem_we_out), 32'(v.st));
        chk({v.nm, ".addr"}, dmem_addr_out, v.e_addr);
        chk({v.nm, ".wstrb"}, 32'(dmem_wstrb_out), 32'(v.e_wstrb));
        if (v.st) chk({v.nm, ".wdata"}, dmem_wdata_out, v.e_wdata);
        for (int i = 0; i < v.gd; i++) begin
            step();
            chk({v.nm, ".req_hold"}, 32'(dmem_req_out), 32'd1);
            chk({v.nm, ".addr_hold"}, dmem_addr_out, v.e_addr);
        end
        dmem_gnt_in = 1'b1;
        step();
        dmem_gnt_in = 1'b0;
        if (v.ld) begin
            chk({v.nm, ".req_rsp"}, 32'(dmem_req_out), 32'd0);
            chk({v.nm, ".stall_rsp"}, 32'(stall_out), 32'd1);
            dmem_rvalid_in = 1'b1;
            dmem_rdata_in  = v.rdata;
            step();
            dmem_rvalid_in = 1'b0;
        end
        chk({v.nm, ".wb_valid"}, 32'(wb_valid_out), 32'd1);
        chk({v.nm, ".stall_done"}, 32'(stall_out), 32'd0);
        chk({v.nm, ".wb_data"}, wb_data_out, v.e_wb);
        chk({v.nm, ".rf_wr"}, 32'(wb_rf_wr_out), 32'(v.e_rf));
        chk({v.nm, ".rd"}, 32'(wb_rd_addr_out), 32'(v.rd));
        chk({v.nm, ".bus_err"}, 32'(bus_err_out), 32'd0);
        chk({v.nm, ".misalign"}, 32'(misalign_out), 32'd0);
        clear_op();
        step();
        chk({v.nm, ".wb_pulse_end"}, 32'(wb_valid_out), 32'd0);
        chk({v.nm, ".req_idle"}, 32'(dmem_req_out), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   n;

        //         name       ld  st  sz    uns addr          wdata         rd  gd rdata         e_addr        e_wstrb  e_wdata       e_wb          e_rf
        vecs[0] = '{"sw",    0, 1, 2'd2, 0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 2, 32'h0,         32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0,         0};
        vecs[1] = '{"sb",    0, 1, 2'd0, 0, 32'h0000_0103, 32'h0000_00A5, 5'd0, 0, 32'h0,         32'h0000_0100, 4'h8, 32'hA5A5_A5A5, 32'h0,         0};
        vecs[2] = '{"lb",    1, 0, 2'd0, 0, 32'h0000_0103, 32'h0,         5'd3, 0, 32'hA500_0000, 32'h0000_0100, 4'h0, 32'h0,         32'hFFFF_FFA5, 1};
        vecs[3] = '{"lbu",   1, 0, 2'd0, 1, 32'h0000_0103, 32'h0,         5'd3, 1, 32'hA500_0000, 32'h0000_0100, 4'h0, 32'h0,         32'h0000_00A5, 1};
        vecs[4] = '{"lh_rd0",1, 0, 2'd1, 0, 32'h0000_0102, 32'h0,         5'd0, 0, 32'h8001_7FFF, 32'h0000_0100, 4'h0, 32'h0,         32'hFFFF_8001, 0};
        vecs[5] = '{"lhu",   1, 0, 2'd1, 1, 32'h0000_0100, 32'h0,         5'd7, 0, 32'h8001_7FFF, 32'h0000_0100, 4'h0, 32'h0,         32'h0000_7FFF, 1};
        vecs[6] = '{"sh",    0, 1, 2'd1, 0, 32'h0000_0102, 32'h1234_ABCD, 5'd1, 1, 32'h0,         32'h0000_0100, 4'hC, 32'hABCD_ABCD, 32'h0,         0};
        vecs[7] = '{"lw",    1, 0, 2'd3, 0, 32'h0000_0200, 32'h0,         5'd31,1, 32'h1234_5678, 32'h0000_0200, 4'h0, 32'h0,         32'h1234_5678, 1};
        vecs[8] = '{"lb1",   1, 0, 2'd0, 0, 32'h0000_0101, 32'h0,         5'd2, 0, 32'h0000_7F00, 32'h0000_0100, 4'h0, 32'h0,         32'h0000_007F, 1};
        vecs[9] = '{"sb0",   0, 1, 2'd0, 0, 32'h0000_0040, 32'hFFFF_FF5A, 5'd2, 0, 32'h0,         32'h0000_0040, 4'h1, 32'h5A5A_5A5A, 32'h0,         0};

        // Reset state with reset held.
        #1;
        chk("rst.ctrl", 32'({dmem_req_out, dmem_we_out, dmem_wstrb_out, stall_out, wb_valid_out,
                             wb_rf_wr_out, bus_err_out, misalign_out}), 32'd0);
        chk("rst.addr", dmem_addr_out, 32'd0);
        chk("rst.wb_data", wb_data_out, 32'd0);
        step();
        rst_in = 1'b1;
        step();

        // Non-memory op is ignored.
        valid_in = 1'b1; load_in = 1'b0; store_in = 1'b0;
        #1;
        chk("nonmem.stall", 32'(stall_out), 32'd0);
        step();
        chk("nonmem.req", 32'(dmem_req_out), 32'd0);
        chk("nonmem.stall2", 32'(stall_out), 32'd0);
        clear_op();
        step();

        for (int i = 0; i < 10; i++) do_op(vecs[i]);

        // Timeout: granted load that never sees rvalid.
        v = '{"tmo", 1, 0, 2'd2, 0, 32'h0000_0300, 32'h0, 5'd4, 0, 32'h0, 32'h0000_0300, 4'h0, 32'h0, 32'h0, 0};
        drive_op(v);
        step();
        dmem_gnt_in = 1'b1;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            dmem_gnt_in = 1'b0;
            if (k == 1) chk("tmo.req_rsp", 32'(dmem_req_out), 32'd0);
            if (wb_valid_out) begin
                n = k;
                break;
            end
        end
        chk("tmo.cycles", n, 32'd16);
        chk("tmo.bus_err", 32'(bus_err_out), 32'd1);
        chk("tmo.rf_wr", 32'(wb_rf_wr_out), 32'd0);
        chk("tmo.wb_data", wb_data_out, 32'd0);
        chk("tmo.stall", 32'(stall_out), 32'd0);
        clear_op();
        step();
        chk("tmo.err_end", 32'(bus_err_out), 32'd0);
        do_op(vecs[7]);

        // Misaligned word load at 0x101.
        v = '{"lw_mis", 1, 0, 2'd2, 0, 32'h0000_0101, 32'h0, 5'd9, 0, 32'hCAFE_F00D, 32'h0000_0100, 4'h0, 32'h0, 32'hCAFE_F00D, 1};
`ifdef MISALIGN_TRAP_EN
        drive_op(v);
        step();
        chk("mis.req", 32'(dmem_req_out), 32'd0);
        chk("mis.wb_valid", 32'(wb_valid_out), 32'd1);
        chk("mis.misalign", 32'(misalign_out), 32'd1);
        chk("mis.rf_wr", 32'(wb_rf_wr_out), 32'd0);
        clear_op();
        step();
        chk("mis.end", 32'(misalign_out), 32'd0);
`else
        do_op(v);
`endif

        // Asynchronous reset while waiting in RSP.
        drive_op(vecs[7]);
        step();
        dmem_gnt_in = 1'b1;
        step();
        dmem_gnt_in = 1'b0;
        chk("arst.in_rsp", 32'(stall_out), 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst.ctrl", 32'({dmem_req_out, dmem_we_out, dmem_wstrb_out, stall_out, wb_valid_out,
                              wb_rf_wr_out, bus_err_out, misalign_out}), 32'd0);
        chk("arst.addr", dmem_addr_out, 32'd0);
        chk("arst.wdata", dmem_wdata_out, 32'd0);
        chk("arst.wb", 32'({wb_rd_addr_out, wb_data_out[26:0]}), 32'd0);
        clear_op();
        step();
        rst_in = 1'b1;
        step();
        chk("arst.stall_after", 32'(stall_out), 32'd0);
        chk("arst.req_after", 32'(dmem_req_out), 32'd0);
        step();
        chk("arst.stall_after2", 32'(stall_out), 32'd0);
        do_op(vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
